// File: rtl/x1_vid_pkg.sv
// Shared definitions for the X1 video path: attribute bit positions,
// colour constants and the palette entry layout.
package x1_vid_pkg;

  localparam int ATT_H2X   = 7;
  localparam int ATT_V2X   = 6;
  localparam int ATT_PCG   = 5;
  localparam int ATT_BLINK = 4;
  localparam int ATT_REV   = 3;
  localparam int ATT_G     = 2;
  localparam int ATT_R     = 1;
  localparam int ATT_B     = 0;

  localparam logic [2:0] COL_BLACK = 3'b000;

  localparam int PAL_W      = 4;
  localparam int PAL_PRIO   = 3;
  localparam int PAL_COL_HI = 2;
  localparam int PAL_COL_LO = 0;

  typedef struct packed {
    logic       prio;
    logic [2:0] col;
  } pal_entry_t;

  // Text colour from the CG MSBs: without PCG all three guns follow the CG row.
  function automatic logic [2:0] text_pixel(input logic [7:0] att,
                                            input logic       g_msb,
                                            input logic       r_msb,
                                            input logic       b_msb,
                                            input logic       blink);
    logic [2:0] raw;
    logic       inv;
    raw = {g_msb,
           att[ATT_PCG] ? r_msb : g_msb,
           att[ATT_PCG] ? b_msb : g_msb} & {att[ATT_G], att[ATT_R], att[ATT_B]};
    inv = att[ATT_REV] ^ (att[ATT_BLINK] & blink);
    return raw ^ {3{inv}};
  endfunction

endpackage

// File: rtl/x1_pal_ram.sv
// Palette/priority table: one synchronous write port, one asynchronous read
// port, so a same-index read during a write still sees the old entry.
module x1_pal_ram
  import x1_vid_pkg::*;
#(
  parameter int PLANES = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [PLANES-1:0] widx_i,
  input  pal_entry_t        wdata_i,
  input  logic [PLANES-1:0] ridx_i,
  output pal_entry_t        rdata_o
);

  localparam int ENTRIES = 1 << PLANES;

  pal_entry_t [ENTRIES-1:0] mem_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q <= '0;
    end else if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/x1_pixmix.sv
// X1/X1turbo pixel serialiser and text/graphic mixer: shifts CG/PCG and
// graphic planes, applies attributes, blink, palette priority and black control.
module x1_pixmix
  import x1_vid_pkg::*;
#(
  parameter int PLANES    = 3,
  parameter int PIXW      = 8,
  parameter int BLINK_DIV = 16
) (
  input  logic                   I_VCLK,
  input  logic                   I_RESET,
  input  logic                   I_PIX_EN,
  input  logic                   I_LOAD,
  input  logic                   I_DISP,
  input  logic                   I_VSYNC,
  input  logic                   I_H2X_ODD,
  input  logic [7:0]             I_ATT,
  input  logic [PIXW-1:0]        I_CG,
  input  logic [PIXW-1:0]        I_PCGB,
  input  logic [PIXW-1:0]        I_PCGR,
  input  logic [PIXW-1:0]        I_PCGG,
  input  logic [PLANES*PIXW-1:0] I_GR,
  input  logic                   I_PAL_WE,
  input  logic [PLANES-1:0]      I_PAL_IDX,
  input  logic [3:0]             I_PAL_D,
  input  logic [2:0]             I_BLACK_COL,
  input  logic                   I_TXT_BLACK,
  input  logic                   I_GR0_BLACK,
  input  logic                   I_GR1_BLACK,
  input  logic                   I_BLK_BLACK,
  output logic [2:0]             O_COL,
  output logic                   O_YM,
  output logic                   O_DISP,
  output logic                   O_BLINK
);

  localparam logic [7:0] BLINK_LAST = 8'(BLINK_DIV - 1);

  logic                   disp_q, disp_d;
  logic [7:0]             att_q, att_d;
  logic [PLANES-1:0][PIXW-1:0] gr_q, gr_d;
  logic [PIXW-1:0]        cgb_q, cgb_d, cgr_q, cgr_d, cgg_q, cgg_d;
  logic                   tog_q, tog_d;
  logic                   vs_q, vs_d;
  logic [7:0]             bcnt_q, bcnt_d;
  logic                   blink_q, blink_d;
  logic [2:0]             col_q, col_d;
  logic                   ym_q, ym_d;
  logic                   odisp_q, odisp_d;

  logic                   cg_shift;
  logic [PLANES-1:0]      gi;
  logic [2:0]             txt_col;
  logic                   txt_clear;
  logic                   gr_sel;
  logic                   black;
  logic [2:0]             mix_col;
  pal_entry_t             pal_rd;
  pal_entry_t             pal_wd;

  assign pal_wd = pal_entry_t'(I_PAL_D);

  x1_pal_ram #(
    .PLANES (PLANES)
  ) u_pal (
    .clk_i   (I_VCLK),
    .rst_i   (I_RESET),
    .we_i    (I_PAL_WE),
    .widx_i  (I_PAL_IDX),
    .wdata_i (pal_wd),
    .ridx_i  (gi),
    .rdata_o (pal_rd)
  );

  // Shift/load of the pixel registers and the VSYNC blink timebase.
  always_comb begin
    disp_d  = disp_q;
    att_d   = att_q;
    gr_d    = gr_q;
    cgb_d   = cgb_q;
    cgr_d   = cgr_q;
    cgg_d   = cgg_q;
    tog_d   = tog_q;
    vs_d    = I_VSYNC;
    bcnt_d  = bcnt_q;
    blink_d = blink_q;

    cg_shift = ~att_q[ATT_H2X] | tog_q;

    if (I_VSYNC & ~vs_q) begin
      if (bcnt_q == BLINK_LAST) begin
        bcnt_d  = 8'd0;
        blink_d = ~blink_q;
      end else begin
        bcnt_d  = bcnt_q + 8'd1;
        blink_d = blink_q;
      end
    end else begin
      bcnt_d  = bcnt_q;
      blink_d = blink_q;
    end

    if (I_PIX_EN) begin
      tog_d = ~tog_q;
      if (I_LOAD) begin
        disp_d = I_DISP;
        att_d  = I_ATT;
        tog_d  = 1'b0;
        for (int p = 0; p < PLANES; p++) begin
          gr_d[p] = I_GR[p*PIXW +: PIXW];
        end
        // The odd half of a double-width cell keeps the even cell's CG row,
        // and its load strobe still counts as that row's last pixel advance.
        if (I_ATT[ATT_H2X] & I_H2X_ODD) begin
          if (cg_shift) begin
            cgb_d = {cgb_q[PIXW-2:0], 1'b0};
            cgr_d = {cgr_q[PIXW-2:0], 1'b0};
            cgg_d = {cgg_q[PIXW-2:0], 1'b0};
          end else begin
            cgb_d = cgb_q;
            cgr_d = cgr_q;
            cgg_d = cgg_q;
          end
        end else begin
          cgb_d = I_PCGB;
          cgr_d = I_PCGR;
          cgg_d = I_ATT[ATT_PCG] ? I_PCGG : I_CG;
        end
      end else begin
        for (int p = 0; p < PLANES; p++) begin
          gr_d[p] = {gr_q[p][PIXW-2:0], 1'b0};
        end
        if (cg_shift) begin
          cgb_d = {cgb_q[PIXW-2:0], 1'b0};
          cgr_d = {cgr_q[PIXW-2:0], 1'b0};
          cgg_d = {cgg_q[PIXW-2:0], 1'b0};
        end else begin
          cgb_d = cgb_q;
          cgr_d = cgr_q;
          cgg_d = cgg_q;
        end
      end
    end else begin
      tog_d = tog_q;
    end
  end

  // Text/graphic mix, palette priority and black masking of the current pixel.
  always_comb begin
    for (int p = 0; p < PLANES; p++) begin
      gi[p] = disp_q & gr_q[p][PIXW-1];
    end

    txt_col   = text_pixel(att_q, cgg_q[PIXW-1], cgr_q[PIXW-1], cgb_q[PIXW-1], blink_q);
    txt_clear = (txt_col == COL_BLACK);
    gr_sel    = pal_rd.prio | txt_clear | ~disp_q;

    if (~disp_q) begin
      mix_col = COL_BLACK;
      black   = I_BLK_BLACK;
    end else if (gr_sel) begin
      mix_col = pal_rd.col;
      black   = (gi[PLANES-1:1] == '0) & (gi[0] ? I_GR1_BLACK : I_GR0_BLACK);
    end else begin
      mix_col = txt_col;
      black   = I_TXT_BLACK & (txt_col == I_BLACK_COL);
    end

    col_d   = black ? COL_BLACK : mix_col;
    ym_d    = black;
    odisp_d = disp_q;
  end

  // State and output registers; VSYNC held high across reset is not an edge.
  always_ff @(posedge I_VCLK) begin
    if (I_RESET) begin
      disp_q  <= 1'b0;
      att_q   <= 8'h00;
      gr_q    <= '0;
      cgb_q   <= '0;
      cgr_q   <= '0;
      cgg_q   <= '0;
      tog_q   <= 1'b0;
      vs_q    <= 1'b1;
      bcnt_q  <= 8'd0;
      blink_q <= 1'b0;
      col_q   <= COL_BLACK;
      ym_q    <= 1'b0;
      odisp_q <= 1'b0;
    end else begin
      disp_q  <= disp_d;
      att_q   <= att_d;
      gr_q    <= gr_d;
      cgb_q   <= cgb_d;
      cgr_q   <= cgr_d;
      cgg_q   <= cgg_d;
      tog_q   <= tog_d;
      vs_q    <= vs_d;
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
      col_q   <= col_d;
      ym_q    <= ym_d;
      odisp_q <= odisp_d;
    end
  end

  assign O_COL   = col_q;
  assign O_YM    = ym_q;
  assign O_DISP  = odisp_q;
  assign O_BLINK = blink_q;

endmodule
